// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one integer ALU between two requesters.
//   req0 = execute stage, req1 = address/CSR helper.
//   The block arbitrates between the two requesters and latches the winner's operands.
//   It drives the ALU, waits out multi-cycle serial shifts and returns the result.
//   Each result goes back to the winner over its own valid/ready response channel.
//
// Parameters:
//   PRIO_FIXED  0 = round-robin when both request, 1 = req0 always wins
//   PERF_W      width of the performance counters
//
// Ports:
//   i_clk_n, i_rst                     clock (posedge), synchronous active-high reset
//   i_reqN_valid / o_reqN_ready        request handshake (N = 0, 1)
//   i_reqN_a/_b/_funct3/_funct7/_imm   request operands
//   o_rspN_valid / i_rspN_ready        response handshake
//   o_rsp_data                         result, shared by both response channels
//   o_alu_a/_b/_funct3/_funct7/_imm    latched ALU operands
//   o_alu_en                           ALU enable
//   i_alu_busy, i_alu_out              ALU shift-in-progress flag and result
//   o_perf_ops0/1, o_perf_stall        per-requester accept count, WAIT cycle count
//
// Optional feature: define ALU_PERF_CNT_EN to build the performance counters;
// otherwise the counter ports are tied to zero.

module alu_arbiter #(
  parameter int unsigned PRIO_FIXED = 0,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              i_clk_n,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [31:0]       i_req0_a,
  input  logic [31:0]       i_req0_b,
  input  logic [2:0]        i_req0_funct3,
  input  logic [6:0]        i_req0_funct7,
  input  logic              i_req0_imm,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [31:0]       i_req1_a,
  input  logic [31:0]       i_req1_b,
  input  logic [2:0]        i_req1_funct3,
  input  logic [6:0]        i_req1_funct7,
  input  logic              i_req1_imm,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [31:0]       o_rsp_data,
  output logic [31:0]       o_alu_a,
  output logic [31:0]       o_alu_b,
  output logic [2:0]        o_alu_funct3,
  output logic [6:0]        o_alu_funct7,
  output logic              o_alu_imm,
  output logic              o_alu_en,
  input  logic              i_alu_busy,
  input  logic [31:0]       i_alu_out,
  output logic [PERF_W-1:0] o_perf_ops0,
  output logic [PERF_W-1:0] o_perf_ops1,
  output logic [PERF_W-1:0] o_perf_stall
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        id_q, id_d;           // requester owning the in-flight op
  logic        rr_last_q, rr_last_d; // requester granted last
  logic [31:0] result_q, result_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic        imm_q;

  logic        grant0, grant1;
  logic        is_shift;
  logic        rsp_ready_sel;

  // Grants happen only in IDLE once any leftover shift has drained. Reset gates
  // ready so that a request is never acknowledged in a cycle whose state is discarded.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && !i_alu_busy && !i_rst) begin
      if (i_req0_valid && i_req1_valid) begin
        if (PRIO_FIXED != 0 || rr_last_q) grant0 = 1'b1;
        else                              grant1 = 1'b1;
      end else begin
        grant0 = i_req0_valid;
        grant1 = i_req1_valid;
      end
    end
  end

  assign is_shift      = (f3_q == 3'b001) || (f3_q == 3'b101);
  assign rsp_ready_sel = id_q ? i_rsp1_ready : i_rsp0_ready;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          state_d   = StIssue;
          id_d      = grant1;
          rr_last_d = grant1;
        end
      end
      StIssue: begin
        if (is_shift) begin
          state_d = StWait;
        end else begin
          result_d = i_alu_out;
          state_d  = StResp;
        end
      end
      StWait: begin
        if (!i_alu_busy) begin
          result_d = i_alu_out;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_sel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      state_q   <= StIdle;
      id_q      <= 1'b0;
      rr_last_q <= 1'b1;
      result_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      imm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
      result_q  <= result_d;
      if (grant0 || grant1) begin
        a_q   <= grant1 ? i_req1_a      : i_req0_a;
        b_q   <= grant1 ? i_req1_b      : i_req0_b;
        f3_q  <= grant1 ? i_req1_funct3 : i_req0_funct3;
        f7_q  <= grant1 ? i_req1_funct7 : i_req0_funct7;
        imm_q <= grant1 ? i_req1_imm    : i_req0_imm;
      end
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign o_rsp0_valid = (state_q == StResp) && !id_q;
  assign o_rsp1_valid = (state_q == StResp) && id_q;
  assign o_rsp_data   = result_q;
  assign o_alu_a      = a_q;
  assign o_alu_b      = b_q;
  assign o_alu_funct3 = f3_q;
  assign o_alu_funct7 = f7_q;
  assign o_alu_imm    = imm_q;
  assign o_alu_en     = (state_q == StIssue) || (state_q == StWait);

`ifdef ALU_PERF_CNT_EN
  logic [PERF_W-1:0] ops0_q, ops1_q, stall_q;

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      ops0_q  <= '0;
      ops1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (grant0)             ops0_q  <= ops0_q + 1'b1;
      if (grant1)             ops1_q  <= ops1_q + 1'b1;
      if (state_q == StWait)  stall_q <= stall_q + 1'b1;
    end
  end

  assign o_perf_ops0  = ops0_q;
  assign o_perf_ops1  = ops1_q;
  assign o_perf_stall = stall_q;
`else
  assign o_perf_ops0  = '0;
  assign o_perf_ops1  = '0;
  assign o_perf_stall = '0;
`endif

endmodule
